// File: rtl/laser_host_if.sv
// Host-side bundle for laser_host: system table/command/result signals plus the engine link.
// slave = the host block itself; master = the system and engine that surround it.
interface laser_host_if;
  logic       WEN;
  logic [5:0] WADDR;
  logic [3:0] WX;
  logic [3:0] WY;
  logic       START;

  logic       LRST;
  logic [3:0] X;
  logic [3:0] Y;
  logic       DONE;
  logic [3:0] C1X;
  logic [3:0] C1Y;
  logic [3:0] C2X;
  logic [3:0] C2Y;

  logic       BUSY;
  logic       VALID;
  logic       TIMEOUT;
  logic [5:0] SCORE;
  logic [3:0] R1X;
  logic [3:0] R1Y;
  logic [3:0] R2X;
  logic [3:0] R2Y;

  modport slave (
    input  WEN, WADDR, WX, WY, START, DONE, C1X, C1Y, C2X, C2Y,
    output LRST, X, Y, BUSY, VALID, TIMEOUT, SCORE, R1X, R1Y, R2X, R2Y
  );

  modport master (
    output WEN, WADDR, WX, WY, START, DONE, C1X, C1Y, C2X, C2Y,
    input  LRST, X, Y, BUSY, VALID, TIMEOUT, SCORE, R1X, R1Y, R2X, R2Y
  );
endinterface

// File: rtl/laser_host.sv
// Drives the laser engine with a 40-point table, captures its two centers and scores coverage.
// START to VALID = 1+2+NPTS+wait+NPTS+1 cycles; START/WEN while BUSY are dropped, no other backpressure.
module laser_host #(
  parameter int NPTS      = 40,
  parameter int RADIUS_SQ = 16,
  parameter int TMO_W     = 20
) (
  input  logic        CLK,
  input  logic        RST,
  laser_host_if.slave bus
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ENG_RST,
    ST_FEED,
    ST_WAIT,
    ST_SCORE,
    ST_REPORT
  } state_t;

  localparam logic [5:0]       LAST_IDX = 6'(NPTS - 1);
  localparam logic [5:0]       NPTS_W   = 6'(NPTS);
  localparam logic [TMO_W-1:0] TMO_PRE  = {{(TMO_W-1){1'b1}}, 1'b0};

  state_t           state;
  state_t           state_nxt;

  logic [3:0]       tab_x [NPTS];
  logic [3:0]       tab_y [NPTS];
  logic [5:0]       idx;
  logic             eng_cnt;
  logic [TMO_W-1:0] tmo_cnt;
  logic [5:0]       acc;

  logic             lrst;
  logic [3:0]       x_q;
  logic [3:0]       y_q;
  logic             busy;
  logic             valid;
  logic             timeout;
  logic [5:0]       score;
  logic [3:0]       r1x;
  logic [3:0]       r1y;
  logic [3:0]       r2x;
  logic [3:0]       r2y;

  logic             start_ok;
  logic             done_take;
  logic             tmo_hit;
  logic             hit;

  // All arithmetic stays unsigned: |d| is 4 bits, d^2 8 bits, sum 9 bits.
  function automatic logic in_circle(input logic [3:0] px, input logic [3:0] py,
                                     input logic [3:0] cx, input logic [3:0] cy);
    logic [3:0] dx;
    logic [3:0] dy;
    logic [7:0] sx;
    logic [7:0] sy;
    logic [8:0] sum;
    dx  = (px >= cx) ? px - cx : cx - px;
    dy  = (py >= cy) ? py - cy : cy - py;
    sx  = {4'd0, dx} * {4'd0, dx};
    sy  = {4'd0, dy} * {4'd0, dy};
    sum = {1'b0, sx} + {1'b0, sy};
    return sum <= 9'(RADIUS_SQ);
  endfunction

  assign hit = in_circle(tab_x[idx], tab_y[idx], r1x, r1y) |
               in_circle(tab_x[idx], tab_y[idx], r2x, r2y);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    start_ok  = 1'b0;
    done_take = 1'b0;
    tmo_hit   = 1'b0;
    case (state)
      ST_IDLE: begin
        start_ok = bus.START;
        if (bus.START) state_nxt = ST_ENG_RST;
      end
      ST_ENG_RST: begin
        if (eng_cnt) state_nxt = ST_FEED;
      end
      ST_FEED: begin
        if (idx == LAST_IDX) state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        // DONE takes priority over a timeout landing on the same cycle.
        done_take = bus.DONE;
        tmo_hit   = !bus.DONE && (tmo_cnt == TMO_PRE);
        if (done_take) state_nxt = ST_SCORE;
        else if (tmo_hit) state_nxt = ST_IDLE;
      end
      ST_SCORE: begin
        if (idx == LAST_IDX) state_nxt = ST_REPORT;
      end
      ST_REPORT: begin
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < NPTS; i++) begin
        tab_x[i] <= 4'd0;
        tab_y[i] <= 4'd0;
      end
      idx     <= 6'd0;
      eng_cnt <= 1'b0;
      tmo_cnt <= '0;
      acc     <= 6'd0;
      lrst    <= 1'b1;
      x_q     <= 4'd0;
      y_q     <= 4'd0;
      busy    <= 1'b0;
      valid   <= 1'b0;
      timeout <= 1'b0;
      score   <= 6'd0;
      r1x     <= 4'd0;
      r1y     <= 4'd0;
      r2x     <= 4'd0;
      r2y     <= 4'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          lrst    <= 1'b0;
          idx     <= 6'd0;
          eng_cnt <= 1'b0;
          // A write in the START cycle still lands, so the run sees it.
          if (bus.WEN && (bus.WADDR < NPTS_W)) begin
            tab_x[bus.WADDR] <= bus.WX;
            tab_y[bus.WADDR] <= bus.WY;
          end
          if (start_ok) begin
            busy    <= 1'b1;
            valid   <= 1'b0;
            timeout <= 1'b0;
          end
        end
        ST_ENG_RST: begin
          lrst    <= 1'b1;
          eng_cnt <= 1'b1;
        end
        ST_FEED: begin
          lrst    <= 1'b0;
          x_q     <= tab_x[idx];
          y_q     <= tab_y[idx];
          idx     <= (idx == LAST_IDX) ? 6'd0 : idx + 6'd1;
          tmo_cnt <= '0;
        end
        ST_WAIT: begin
          if (done_take) begin
            r1x     <= bus.C1X;
            r1y     <= bus.C1Y;
            r2x     <= bus.C2X;
            r2y     <= bus.C2Y;
            tmo_cnt <= '0;
            acc     <= 6'd0;
          end else if (tmo_hit) begin
            tmo_cnt <= '0;
            timeout <= 1'b1;
            busy    <= 1'b0;
            lrst    <= 1'b1;
          end else begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
          end
        end
        ST_SCORE: begin
          acc <= acc + {5'd0, hit};
          idx <= (idx == LAST_IDX) ? 6'd0 : idx + 6'd1;
        end
        ST_REPORT: begin
          score <= acc;
          valid <= 1'b1;
          busy  <= 1'b0;
          lrst  <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.LRST    = lrst;
  assign bus.X       = x_q;
  assign bus.Y       = y_q;
  assign bus.BUSY    = busy;
  assign bus.VALID   = valid;
  assign bus.TIMEOUT = timeout;
  assign bus.SCORE   = score;
  assign bus.R1X     = r1x;
  assign bus.R1Y     = r1y;
  assign bus.R2X     = r2x;
  assign bus.R2Y     = r2y;

endmodule

// File: doc/laser_host.md
Name: laser_host

Overview:
- Host-side driver and scorer for the two-circle laser-placement engine.
- Holds a 40-entry target table written by the system, restarts the engine, and streams the 40 targets to it as X/Y on 40 consecutive cycles.
- Waits for the engine's DONE, captures both centers, and independently counts the targets covered by either radius-4 circle.
- Reports SCORE and the centers, with a timeout if DONE never arrives.

Parameters:
- NPTS, 40, number of targets per pattern (fixed protocol length).
- RADIUS_SQ, 16, coverage threshold: covered iff dx*dx + dy*dy <= RADIUS_SQ.
- TMO_W, 20, width of the DONE-wait timeout counter; timeout at 2^TMO_W - 1 cycles.

Ports:
- CLK  in  1  clock, all logic on rising edge.
- RST  in  1  asynchronous, active-high reset.
- WEN  in  1  table write strobe.
- WADDR  in  6  table index 0..NPTS-1.
- WX  in  4  target x.
- WY  in  4  target y.
- START  in  1  one-cycle request to run a pattern.
- LRST  out  1  engine reset, registered.
- X  out  4  target x to engine, registered.
- Y  out  4  target y to engine, registered.
- DONE  in  1  engine result valid.
- C1X, C1Y, C2X, C2Y  in  4 each  engine centers, valid while DONE=1.
- BUSY  out  1  high from accepted START until VALID or TIMEOUT.
- VALID  out  1  result ready; held until the next accepted START.
- TIMEOUT  out  1  DONE not seen in time; held until the next accepted START.
- SCORE  out  6  covered-target count, 0..40.
- R1X, R1Y, R2X, R2Y  out  4 each  captured centers.

Behaviour:
- Reset values:
  - LRST=1, so the engine stays in reset while the host is reset.
  - X=Y=0; BUSY=VALID=TIMEOUT=0; SCORE=0; R*=0.
  - Table contents are reset to 0.
  - State returns to IDLE; a reset mid-run aborts the run with no result.
- States:
  - IDLE
    - LRST=0 after the first cycle out of reset.
    - WEN with WADDR<NPTS writes the table.
    - WADDR>=NPTS is ignored.
    - START -> ENG_RST and sets BUSY; VALID and TIMEOUT clear the same edge.
  - ENG_RST
    - LRST=1 for exactly 2 cycles, then -> FEED with index=0.
  - FEED
    - LRST=0; X/Y present table[i] during the i-th cycle after LRST falls, i=0..NPTS-1, one point per cycle with no gaps.
    - After i=NPTS-1 -> WAIT; X/Y hold the last point.
  - WAIT
    - The timeout counter increments each cycle.
    - DONE=1 -> capture C1X..C2Y into R1X..R2Y, clear the counter, -> SCORE.
    - Counter reaching all-ones first -> TIMEOUT=1, BUSY=0, LRST=1, -> IDLE; SCORE unchanged.
    - DONE and timeout on the same cycle: DONE wins.
  - SCORE
    - Processes one table entry per cycle, NPTS cycles.
    - dx=|x-Rcx| and dy=|y-Rcy| are 4-bit unsigned; squares are 8-bit; the sum is 9-bit, compared <= RADIUS_SQ.
    - A point counts once if inside either circle.
    - The accumulator is 6-bit and cannot overflow (max 40).
    - -> REPORT.
  - REPORT
    - SCORE <= accumulator, VALID=1, BUSY=0, LRST=1 (engine parked), -> IDLE.
- Latency: START to VALID = 1 + 2 + NPTS + (wait cycles) + NPTS + 1 cycles.
- START while BUSY is ignored.
- WEN while BUSY is ignored, so the table stays frozen during a run.
- START and WEN in the same IDLE cycle: the write is performed, and the new value is used by the run.
- DONE outside WAIT is ignored.

Test Plan:
- Write all 40 entries (8,8); bench responder returns C1=(8,8), C2=(0,0) -> VALID, SCORE=40, R1X=8, R1Y=8, R2X=0, R2Y=0.
- Entries 0..19=(5,5), 20..39=(0,15); responder C1=(3,3), C2=(12,12) -> SCORE=20.
- Threshold boundary: entries 0..19=(7,3), 20..39=(8,3); C1=C2=(3,3) -> SCORE=20 (16 covered, 25 not).
- Protocol timing: monitor shows LRST high exactly 2 cycles, then X/Y=table[0..39] on 40 consecutive cycles; START and WEN issued during FEED have no effect; BUSY stays 1 throughout.
- Responder never asserts DONE (TMO_W=4 in bench) -> TIMEOUT=1 after 15 WAIT cycles, VALID=0, SCORE holds the prior value; the next START clears TIMEOUT.
- RST asserted mid-FEED at i=17 -> all outputs at reset values, LRST=1 immediately; a subsequent full run gives the correct SCORE.
